mux_pipe: RTL and testbench

- Parametrised, registered N:1 selector for the MIPS datapath.
- Successor to the fixed 4:1 5-bit combinational destination-select mux.
- Adds configurable width and input count, a valid/ready handshake with a 2-entry skid buffer (full throughput under backpressure), and out-of-range select detection.
- Sits between decode/control and the next pipeline stage, for example register-destination or write-back source selection in the pipelined core.

---
 rtl/mux_pipe.sv | 106 ++++++++++
 tb/tb_mux_pipe.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_pipe.sv
// Registered N:1 selector with a valid/ready handshake and a 2-entry skid buffer.
// Out-of-range selects forward zero data and raise a sticky error flag.
module mux_pipe #(
  parameter int unsigned WIDTH  = 5,
  parameter int unsigned NUM_IN = 4,
  parameter int unsigned SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err,
  input  logic                    clear_err
);

  logic [WIDTH-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d, cap_data;
  logic [SEL_W-1:0] main_sel_q, main_sel_d, skid_sel_q, skid_sel_d;
  logic             main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
  logic             sel_err_q, sel_err_d, in_ready_q;
  logic             cap_oor, accept, main_free;

  // Decode by equality so NUM_IN need not be a power of two.
  always_comb begin
    cap_data = '0;
    cap_oor  = 1'b1;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (in_sel == SEL_W'(k)) begin
        cap_data = in_data[k*WIDTH +: WIDTH];
        cap_oor  = 1'b0;
      end
    end
  end

  assign accept    = in_valid & in_ready_q;
  assign main_free = ~main_valid_q | out_ready;

  always_comb begin
    main_data_d  = main_data_q;
    main_sel_d   = main_sel_q;
    main_valid_d = main_valid_q;
    skid_data_d  = skid_data_q;
    skid_sel_d   = skid_sel_q;
    skid_valid_d = skid_valid_q;
    if (main_free) begin
      if (skid_valid_q) begin
        // in_ready is low while the skid is full, so no accept can collide here.
        main_data_d  = skid_data_q;
        main_sel_d   = skid_sel_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_data_d  = cap_data;
        main_sel_d   = in_sel;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_data_d  = cap_data;
      skid_sel_d   = in_sel;
      skid_valid_d = 1'b1;
    end
  end

  // Set has priority over clear.
  always_comb begin
    sel_err_d = sel_err_q;
    if (clear_err) sel_err_d = 1'b0;
    if (accept && cap_oor) sel_err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_data_q  <= '0;
      main_sel_q   <= '0;
      main_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_sel_q   <= '0;
      skid_valid_q <= 1'b0;
      sel_err_q    <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      main_data_q  <= main_data_d;
      main_sel_q   <= main_sel_d;
      main_valid_q <= main_valid_d;
      skid_data_q  <= skid_data_d;
      skid_sel_q   <= skid_sel_d;
      skid_valid_q <= skid_valid_d;
      sel_err_q    <= sel_err_d;
      in_ready_q   <= ~skid_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_data  = main_data_q;
  assign out_sel   = main_sel_q;
  assign out_valid = main_valid_q;
  assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_mux_pipe.sv
// Directed and randomised checks of mux_pipe in three configurations:
// 5b x 4 inputs, 5b x 3 inputs (out-of-range select), 32b x 16 inputs.
module tb_mux_pipe;

  logic clk, reset;
  int   n_vec, n_err;

  // Configuration A: WIDTH=5, NUM_IN=4, SEL_W=2
  logic [19:0] a_in_data;
  logic [1:0]  a_in_sel, a_out_sel;
  logic [4:0]  a_out_data;
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_sel_err, a_clear_err;
  // Configuration B: WIDTH=5, NUM_IN=3, SEL_W=2
  logic [14:0] b_in_data;
  logic [1:0]  b_in_sel, b_out_sel;
  logic [4:0]  b_out_data;
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_sel_err, b_clear_err;
  // Configuration C: WIDTH=32, NUM_IN=16, SEL_W=4
  logic [511:0] c_in_data;
  logic [3:0]   c_in_sel, c_out_sel;
  logic [31:0]  c_out_data;
  logic         c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_sel_err, c_clear_err;

  logic [31:0] qa[$];
  logic [31:0] qc_data[$];
  logic [3:0]  qc_sel[$];
  int          na_out, nc_in, nc_out;

  mux_pipe #(.WIDTH(5), .NUM_IN(4), .SEL_W(2)) u_a (
    .clk(clk), .reset(reset), .in_data(a_in_data), .in_sel(a_in_sel), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .out_data(a_out_data), .out_sel(a_out_sel), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .sel_err(a_sel_err), .clear_err(a_clear_err)
  );

  mux_pipe #(.WIDTH(5), .NUM_IN(3), .SEL_W(2)) u_b (
    .clk(clk), .reset(reset), .in_data(b_in_data), .in_sel(b_in_sel), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .out_data(b_out_data), .out_sel(b_out_sel), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .sel_err(b_sel_err), .clear_err(b_clear_err)
  );

  mux_pipe #(.WIDTH(32), .NUM_IN(16), .SEL_W(4)) u_c (
    .clk(clk), .reset(reset), .in_data(c_in_data), .in_sel(c_in_sel), .in_valid(c_in_valid),
    .in_ready(c_in_ready), .out_data(c_out_data), .out_sel(c_out_sel), .out_valid(c_out_valid),
    .out_ready(c_out_ready), .sel_err(c_sel_err), .clear_err(c_clear_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [4:0] a_word(input int i, input int k);
    return 5'(i * 3 + k * 7 + 1);
  endfunction

  task automatic load_a(input int i);
    for (int k = 0; k < 4; k++) a_in_data[k*5 +: 5] = a_word(i, k);
    a_in_sel = 2'(i % 4);
  endtask

  // Scoreboard transfers seen before the edge, then advance one clock.
  task automatic tick_a(output logic acc);
    logic [31:0] exp;
    @(negedge clk);
    if (a_out_valid && a_out_ready) begin
      if (qa.size() == 0) begin
        check_eq("a_unexpected_out", 32'(a_out_valid), 32'd0);
      end else begin
        exp = qa.pop_front();
        check_eq("a_order", 32'({a_out_sel, a_out_data}), exp);
        na_out++;
      end
    end
    acc = a_in_valid && a_in_ready;
    if (acc) qa.push_back(32'({a_in_sel, a_in_data[a_in_sel*5 +: 5]}));
    @(posedge clk);
    #1;
  endtask

  task automatic tick_c();
    @(negedge clk);
    if (c_out_valid && c_out_ready) begin
      if (qc_data.size() == 0) begin
        check_eq("c_unexpected_out", 32'(c_out_valid), 32'd0);
      end else begin
        check_eq("c_data", c_out_data, qc_data.pop_front());
        check_eq("c_sel", 32'(c_out_sel), 32'(qc_sel.pop_front()));
        nc_out++;
      end
    end
    if (c_in_valid && c_in_ready) begin
      qc_data.push_back(c_in_data[c_in_sel*32 +: 32]);
      qc_sel.push_back(c_in_sel);
      nc_in++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic acc;
    int   idx;
    n_vec = 0; n_err = 0; na_out = 0; nc_in = 0; nc_out = 0;
    reset = 1'b1;
    a_in_data = '0; a_in_sel = '0; a_in_valid = 0; a_out_ready = 0; a_clear_err = 0;
    b_in_data = '0; b_in_sel = '0; b_in_valid = 0; b_out_ready = 0; b_clear_err = 0;
    c_in_data = '0; c_in_sel = '0; c_in_valid = 0; c_out_ready = 0; c_clear_err = 0;

    #12;
    check_eq("rst_out_valid", 32'(a_out_valid), 0);
    check_eq("rst_out_data", 32'(a_out_data), 0);
    check_eq("rst_out_sel", 32'(a_out_sel), 0);
    check_eq("rst_in_ready", 32'(a_in_ready), 1);
    check_eq("rst_sel_err", 32'(a_sel_err), 0);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    check_eq("post_rst_in_ready", 32'(a_in_ready), 1);

    // Single transfer: inputs {3,17,9,30}, select 2 -> 17
    a_in_data = {5'd3, 5'd17, 5'd9, 5'd30};
    a_in_sel = 2'd2; a_in_valid = 1; a_out_ready = 1;
    tick_a(acc);
    a_in_valid = 0;
    check_eq("single_valid", 32'(a_out_valid), 1);
    check_eq("single_data", 32'(a_out_data), 17);
    check_eq("single_sel", 32'(a_out_sel), 2);
    check_eq("single_err", 32'(a_sel_err), 0);
    tick_a(acc);
    check_eq("single_drained", 32'(a_out_valid), 0);

    // Streaming: 8 back-to-back accepts
    na_out = 0;
    for (int i = 0; i < 8; i++) begin
      load_a(i);
      a_in_valid = 1;
      tick_a(acc);
      check_eq("stream_ready", 32'(a_in_ready), 1);
      check_eq("stream_valid", 32'(a_out_valid), 1);
      check_eq("stream_data", 32'(a_out_data), 32'(a_word(i, i % 4)));
    end
    a_in_valid = 0;
    tick_a(acc);
    tick_a(acc);
    check_eq("stream_count", na_out, 8);

    // Backpressure: out_ready low across edges 2..4
    na_out = 0; idx = 0;
    for (int e = 0; e < 12; e++) begin
      a_out_ready = !(e >= 2 && e <= 4);
      a_in_valid = (idx < 6);
      load_a(idx);
      tick_a(acc);
      if (acc) idx++;
      check_eq("bp_in_ready", 32'(a_in_ready), (e >= 2 && e <= 4) ? 0 : 1);
      if (e >= 2 && e <= 4) begin
        check_eq("bp_hold_valid", 32'(a_out_valid), 1);
        check_eq("bp_hold_data", 32'(a_out_data), 32'(a_word(1, 1)));
      end
    end
    check_eq("bp_accepts", idx, 6);
    check_eq("bp_outputs", na_out, 6);

    // Out-of-range select on a 3-input instance
    b_in_data = {5'd4, 5'd5, 5'd6};
    b_in_sel = 2'd3; b_in_valid = 1; b_out_ready = 1;
    @(posedge clk); #1;
    b_in_valid = 0;
    check_eq("oor_valid", 32'(b_out_valid), 1);
    check_eq("oor_data", 32'(b_out_data), 0);
    check_eq("oor_sel", 32'(b_out_sel), 3);
    check_eq("oor_err", 32'(b_sel_err), 1);
    @(posedge clk); #1;
    check_eq("oor_sticky", 32'(b_sel_err), 1);
    b_clear_err = 1;
    @(posedge clk); #1;
    b_clear_err = 0;
    check_eq("oor_cleared", 32'(b_sel_err), 0);
    b_in_sel = 2'd1; b_in_valid = 1;
    @(posedge clk); #1;
    check_eq("inrange_data", 32'(b_out_data), 5);
    check_eq("inrange_err", 32'(b_sel_err), 0);
    b_in_sel = 2'd3; b_clear_err = 1;
    @(posedge clk); #1;
    b_in_valid = 0; b_clear_err = 0;
    check_eq("set_wins", 32'(b_sel_err), 1);
    check_eq("set_wins_data", 32'(b_out_data), 0);

    // Reset mid-stream with both entries full
    a_out_ready = 0; a_in_valid = 1;
    load_a(20);
    tick_a(acc);
    load_a(21);
    tick_a(acc);
    a_in_valid = 0;
    check_eq("full_in_ready", 32'(a_in_ready), 0);
    #3 reset = 1'b1;
    #1;
    check_eq("midrst_out_valid", 32'(a_out_valid), 0);
    check_eq("midrst_out_data", 32'(a_out_data), 0);
    check_eq("midrst_in_ready", 32'(a_in_ready), 1);
    check_eq("midrst_sel_err", 32'(b_sel_err), 0);
    qa.delete();
    #2 reset = 1'b0;
    @(posedge clk); #1;
    check_eq("release_in_ready", 32'(a_in_ready), 1);
    na_out = 0;
    a_out_ready = 1; a_in_valid = 1;
    load_a(3);
    tick_a(acc);
    a_in_valid = 0;
    check_eq("after_rst_valid", 32'(a_out_valid), 1);
    check_eq("after_rst_data", 32'(a_out_data), 32'(a_word(3, 3)));
    tick_a(acc);
    check_eq("after_rst_single", 32'(a_out_valid), 0);
    check_eq("after_rst_count", na_out, 1);

    // Wide sweep with random handshakes
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int k = 0; k < 16; k++) c_in_data[k*32 +: 32] = $urandom;
      c_in_sel    = 4'($urandom_range(0, 15));
      c_in_valid  = ($urandom_range(0, 3) != 0);
      c_out_ready = ($urandom_range(0, 3) != 0);
      tick_c();
    end
    c_in_valid = 0; c_out_ready = 1;
    for (int cyc = 0; cyc < 6; cyc++) tick_c();
    check_eq("sweep_count", nc_out, nc_in);
    check_eq("sweep_err", 32'(c_sel_err), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
